// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants and types for the bit-serial adder.
// Holds the FSM state encoding (IDLE/SHIFT/DONE) and the default operand width.
// The optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  // Default operand/sum width, and the smallest width the datapath supports.
  localparam int unsigned SA_DEFAULT_WIDTH = 8;
  localparam int unsigned SA_MIN_WIDTH     = 2;

  // Controller states. The encodings are fixed so they line up with other
  // blocks that decode the state (debug, trace).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

  // Counter width for a given operand width. The counter only has to reach
  // WIDTH-1, so ceil(log2(WIDTH)) bits are enough and it never wraps.
  function automatic int unsigned sa_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell, purely combinational.
// This is the cell that serial_adder reuses once per bit.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic a_xor_b;

  // Sum and carry of one bit position.
  assign a_xor_b = A ^ B;
  assign S       = a_xor_b ^ Cin;
  assign Cout    = (A & B) | (Cin & a_xor_b);

endmodule : full_adder

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock, LSB first.
// A single full_adder cell plus a carry flip-flop resolves WIDTH bits in
// WIDTH cycles. After that a one-cycle done pulse presents {Cout,S}.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow port V.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int unsigned     CNT_W    = sa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // The carry flip-flop and counter logic assume at least two bits.
  if (WIDTH < SA_MIN_WIDTH) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 2");
  end

  // Controller state and registered handshake outputs.
  sa_state_e        state_q;
  logic             busy_q;
  logic             done_q;

  // Datapath registers: operand shifters, sum shifter, running carry, bit counter.
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             v_q;
`endif

  // Outputs of the shared single-bit cell.
  logic             fa_s;
  logic             fa_cout;

  // The one full_adder: it always looks at the current LSBs and the carry.
  full_adder u_full_adder (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // Next values of the shifters and counter for one SHIFT step.
  always_comb begin
    a_sr_d = a_sr_q >> 1;
    b_sr_d = b_sr_q >> 1;
    // The new sum bit enters at the MSB. After WIDTH steps bit 0 has reached
    // the LSB, so s_sr holds the result in natural order.
    s_sr_d = {fa_s, s_sr_q[WIDTH-1:1]};
    cnt_d  = cnt_q + CNT_W'(1);
  end

  // Controller and datapath: accept in IDLE, shift WIDTH times, then pulse done.
  // NOTE: every register here is assigned with <=. All of them then update
  // together from the values of the previous cycle, which is what makes the
  // shifters and the carry chain step in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state, including the operand and sum shifters, is reset. There
    // are only a few flops, and a clean S/Cout after an aborted operation is
    // required behaviour.
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Accepting edge: capture the operands and clear the old result.
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            a_sr_q  <= A;
            b_sr_q  <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
            s_sr_q  <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            v_q     <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          a_sr_q  <= a_sr_d;
          b_sr_q  <= b_sr_d;
          s_sr_q  <= s_sr_d;
          carry_q <= fa_cout;
          if (cnt_q == CNT_LAST) begin
            // MSB resolved: publish the carry-out and raise done for one cycle.
            // The counter is left at WIDTH-1 and reloaded on the next start.
            state_q <= DONE;
            done_q  <= 1'b1;
            cout_q  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            v_q     <= carry_q ^ fa_cout;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DONE: begin
          // A start seen here is dropped. It is only sampled in IDLE.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The result comes straight from the registers, so it holds between operations.
  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_sr_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign V    = v_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder.
// An 8-bit instance is driven by a table of directed vectors and by
// hand-written sequences: start while busy, and reset mid-operation.
// A 3-bit instance gets an exhaustive sweep of all 128 input combinations.
// V is checked only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // 8-bit instance signals.
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] s8;
  logic       cout8;
`ifdef SERIAL_ADDER_OVF_EN
  logic       v8;
`endif

  // 3-bit instance signals.
  logic       start3;
  logic [2:0] a3, b3;
  logic       cin3;
  logic       busy3, done3;
  logic [2:0] s3;
  logic       cout3;
`ifdef SERIAL_ADDER_OVF_EN
  logic       v3;
`endif

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .S     (s8),
    .Cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .V     (v8)
`endif
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start3),
    .A     (a3),
    .B     (b3),
    .Cin   (cin3),
    .busy  (busy3),
    .done  (done3),
    .S     (s3),
    .Cout  (cout3)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .V     (v3)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       v;
  } vec_t;

  localparam int N_VECS = 9;
  vec_t vecs [N_VECS];

  // One 8-bit operation, starting from IDLE at #1 after an edge. The task
  // returns #1 after the edge that follows done, when the DUT is idle again.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input string tag, output logic [7:0] s_at_done,
                      output logic cout_at_done, output logic v_at_done);
    int lat;
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk); #1;                       // E0
    start8 = 1'b0;
    check({tag, "_busy_E0"}, busy8, 1);
    check({tag, "_S_cleared_E0"}, s8, 0);
    check({tag, "_Cout_cleared_E0"}, cout8, 0);
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done_latency"}, lat, 8);
    s_at_done    = s8;
    cout_at_done = cout8;
`ifdef SERIAL_ADDER_OVF_EN
    v_at_done    = v8;
`else
    v_at_done    = 1'b0;
`endif
    @(posedge clk); #1;                       // E(WIDTH+1)
    check({tag, "_done_one_cycle"}, done8, 0);
    check({tag, "_busy_fall"}, busy8, 0);
  endtask

  initial begin
    logic [7:0] s_r;
    logic       c_r, v_r;
    int         n_done, done_at;
    logic [7:0] s_done;
    logic       c_done;
    logic [6:0] iv;
    logic [3:0] exp3;
    int         lat;

    vecs[0] = '{a:8'h0F, b:8'h01, cin:1'b0, s:8'h10, cout:1'b0, v:1'b0};
    vecs[1] = '{a:8'hFF, b:8'h01, cin:1'b0, s:8'h00, cout:1'b1, v:1'b0};
    vecs[2] = '{a:8'h7F, b:8'h00, cin:1'b1, s:8'h80, cout:1'b0, v:1'b1};
    vecs[3] = '{a:8'h80, b:8'h80, cin:1'b0, s:8'h00, cout:1'b1, v:1'b1};
    vecs[4] = '{a:8'hAA, b:8'h55, cin:1'b1, s:8'h00, cout:1'b1, v:1'b0};
    vecs[5] = '{a:8'h00, b:8'h00, cin:1'b0, s:8'h00, cout:1'b0, v:1'b0};
    vecs[6] = '{a:8'hFF, b:8'hFF, cin:1'b1, s:8'hFF, cout:1'b1, v:1'b0};
    vecs[7] = '{a:8'h12, b:8'h34, cin:1'b0, s:8'h46, cout:1'b0, v:1'b0};
    vecs[8] = '{a:8'h40, b:8'h40, cin:1'b0, s:8'h80, cout:1'b0, v:1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;

    // Reset state, both during reset and after it is released.
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_S", s8, 0);
    check("rst_Cout", cout8, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy8, 0);
    check("post_rst_done", done8, 0);
    check("post_rst_S", s8, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("post_rst_V", v8, 0);
`endif

    // Table-driven directed vectors.
    for (int i = 0; i < N_VECS; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i), s_r, c_r, v_r);
      check($sformatf("vec%0d_S", i), s_r, vecs[i].s);
      check($sformatf("vec%0d_Cout", i), c_r, vecs[i].cout);
      check($sformatf("vec%0d_S_held", i), s8, vecs[i].s);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("vec%0d_V", i), v_r, vecs[i].v);
`endif
    end

    // Start pulses at E3 and E5 must be ignored; the E0 operands produce the only result.
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;                       // E0
    start8 = 1'b0;
    n_done = 0; done_at = -1; s_done = '0; c_done = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start8 = (k == 3 || k == 5);
      if (start8) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end
      @(posedge clk); #1;                     // E(k)
      if (done8 === 1'b1) begin
        n_done++;
        done_at = k;
        s_done  = s8;
        c_done  = cout8;
      end
    end
    start8 = 1'b0;
    check("busy_start_done_count", n_done, 1);
    check("busy_start_done_cycle", done_at, 8);
    check("busy_start_S", s_done, 8'h10);
    check("busy_start_Cout", c_done, 0);
    check("busy_start_S_held", s8, 8'h10);
    check("busy_start_idle", busy8, 0);

    // Reset at cycle 4 aborts the operation; outputs clear and no done follows.
    a8 = 8'h0F; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;                       // E0
    start8 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_S", s8, 0);
    check("abort_Cout", cout8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_S_still_zero", s8, 0);
    run8(8'h3C, 8'h0A, 1'b1, "after_abort", s_r, c_r, v_r);
    check("after_abort_S", s_r, 8'h47);
    check("after_abort_Cout", c_r, 0);

    // Exhaustive sweep of the 3-bit instance: {A,B,Cin} = i.
    for (int i = 0; i < 128; i++) begin
      iv = 7'(i);
      a3 = iv[6:4]; b3 = iv[3:1]; cin3 = iv[0];
      exp3 = {1'b0, a3} + {1'b0, b3} + {3'b000, cin3};
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      lat = 0;
      while (done3 !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("w3_case%0d_latency", i), lat, 3);
      check($sformatf("w3_case%0d_sum", i), {cout3, s3}, exp3);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
